// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared port ids, FSM encoding and length constants for mem_arbiter
package mc_pkg;

    localparam logic [1:0] PORT_IF  = 2'd1;
    localparam logic [1:0] PORT_MEM = 2'd2;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - two-way grant select; bit 0 = IF, bit 1 = MEM
module arb_pick (
    input  logic [1:0] pend,
    input  logic       ptr,
    output logic [1:0] grant
);

    // ptr high means MEM wins a tie
    always_comb begin
        grant = 2'b00;
        if (pend == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = pend;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter onto one memory controller; MEM_ARBITER_RR_EN selects round-robin
module mem_arbiter
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_len,
    output logic        mem_ack,
    output logic [31:0] rd_data,
    output logic        mc_re,
    output logic        mc_we,
    output logic [1:0]  mc_port_id,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    output logic [2:0]  mc_len,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata,
    output logic        err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          if_pend, mem_pend;
    logic [31:0]   if_addr_q, mem_addr_q, mem_wdata_q;
    logic          mem_we_q;
    logic [2:0]    mem_len_q;
    logic          gnt_mem, gnt_we;
    logic [1:0]    grant;
    logic          ptr;
    logic          start, finish, tmo;
    logic          pick_we, if_clr, mem_clr;

`ifdef MEM_ARBITER_RR_EN
    // Moves only on ties, so the loser of one tie wins the next
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ptr <= 1'b1;
        end else if (rdy_in && start && if_pend && mem_pend) begin
            ptr <= ~grant[1];
        end
    end
`else
    assign ptr = 1'b1;
`endif

    arb_pick u_pick (
        .pend  ({mem_pend, if_pend}),
        .ptr   (ptr),
        .grant (grant)
    );

    assign pick_we = grant[1] & mem_we_q;
    assign if_clr  = finish & ~gnt_mem;
    assign mem_clr = finish & gnt_mem;

    always_comb begin
        state_d = state;
        start   = 1'b0;
        finish  = 1'b0;
        tmo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_pend || mem_pend) begin
                    state_d = ST_ISSUE;
                    start   = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mc_done) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt == TMO_LAST) begin
                    finish  = 1'b1;
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            if_pend     <= 1'b0;
            mem_pend    <= 1'b0;
            if_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_len_q   <= '0;
            gnt_mem     <= 1'b0;
            gnt_we      <= 1'b0;
            if_ack      <= 1'b0;
            mem_ack     <= 1'b0;
            err         <= 1'b0;
            rd_data     <= '0;
            mc_re       <= 1'b0;
            mc_we       <= 1'b0;
            mc_port_id  <= '0;
            mc_addr     <= '0;
            mc_wdata    <= '0;
            mc_len      <= '0;
        end else if (rdy_in) begin
            state   <= state_d;
            if_ack  <= if_clr;
            mem_ack <= mem_clr;
            err     <= tmo;
            mc_re   <= start & ~pick_we;
            mc_we   <= start & pick_we;
            if (start) begin
                gnt_mem    <= grant[1];
                gnt_we     <= pick_we;
                mc_port_id <= grant[1] ? PORT_MEM : PORT_IF;
                mc_addr    <= grant[1] ? mem_addr_q : if_addr_q;
                mc_wdata   <= grant[1] ? mem_wdata_q : 32'd0;
                mc_len     <= grant[1] ? mem_len_q : LEN_4;
                cnt        <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                rd_data <= (tmo || gnt_we) ? 32'd0 : mc_rdata;
            end
            // A latch emptied on this edge may be refilled on the same edge
            if (if_clr) if_pend <= 1'b0;
            if (if_req && (!if_pend || if_clr)) begin
                if_pend   <= 1'b1;
                if_addr_q <= if_addr;
            end
            if (mem_clr) mem_pend <= 1'b0;
            if (mem_req && (!mem_pend || mem_clr)) begin
                mem_pend    <= 1'b1;
                mem_we_q    <= mem_we;
                mem_addr_q  <= mem_addr;
                mem_wdata_q <= mem_wdata;
                mem_len_q   <= mem_len;
            end
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            err     <= 1'b0;
        end
    end

endmodule
